// File: rtl/sample_packer.sv
// Packs 2-bit I/Q samples from one, two or four channels into 16-bit words,
// with integer decimation, shadowed configuration and a counter test pattern.
module sample_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ch1_s,
    input  logic [3:0]  ch2_s,
    input  logic [3:0]  ch3_s,
    input  logic [3:0]  ch4_s,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [3:0]  decim,
    output logic [15:0] out_data,
    output logic        out_en,
    output logic        out_first
);

    logic        enable_q, enable_d;
    logic [1:0]  cmode_q, cmode_d;
    logic [3:0]  cdecim_q, cdecim_d;
    logic        first_pend_q, first_pend_d;
    logic [3:0]  dcnt_q, dcnt_d;
    logic [1:0]  fill_q, fill_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_en_q, out_en_d;
    logic        out_first_q, out_first_d;

    logic        rise;
    logic        cfg_diff;
    logic        copy;
    logic        accept;
    logic [1:0]  eff_mode;
    logic [3:0]  eff_decim;
    logic [15:0] packed_word;
    logic        last;

    always_comb begin
        rise      = enable & ~enable_q;
        cfg_diff  = (mode != cmode_q) || (decim != cdecim_q);
        copy      = enable & (rise | ((fill_q == 2'd0) & cfg_diff));
        // A shadow copy takes effect for the sample accepted on the same edge.
        eff_mode  = copy ? mode  : cmode_q;
        eff_decim = copy ? decim : cdecim_q;
        // The enabling edge only arms the datapath; its sample is never taken.
        accept    = enable & ~rise & (dcnt_q == 4'd0);

        packed_word = acc_q;
        last        = 1'b0;
        case (eff_mode)
            2'd0: begin
                packed_word = {acc_q[11:0], ch1_s};
                last        = (fill_q == 2'd3);
            end
            2'd1: begin
                packed_word = {acc_q[7:0], ch1_s, ch3_s};
                last        = fill_q[0];
            end
            2'd2: begin
                packed_word = {ch1_s, ch2_s, ch3_s, ch4_s};
                last        = 1'b1;
            end
            default: begin
                packed_word = tcnt_q;
                last        = 1'b1;
            end
        endcase
    end

    always_comb begin
        enable_d     = enable;
        cmode_d      = cmode_q;
        cdecim_d     = cdecim_q;
        first_pend_d = first_pend_q;
        dcnt_d       = dcnt_q;
        fill_d       = fill_q;
        acc_d        = acc_q;
        tcnt_d       = tcnt_q;
        out_data_d   = out_data_q;
        out_en_d     = 1'b0;
        out_first_d  = 1'b0;

        if (!enable) begin
            fill_d = 2'd0;
            dcnt_d = 4'd0;
            acc_d  = 16'd0;
        end else begin
            if (copy) begin
                cmode_d      = mode;
                cdecim_d     = decim;
                first_pend_d = 1'b1;
            end
            if (rise) begin
                tcnt_d = 16'd0;
                dcnt_d = 4'd0;
            end else if (accept) begin
                dcnt_d = eff_decim;
                if (eff_mode == 2'd3) begin
                    tcnt_d = tcnt_q + 16'd1;
                end else begin
                    acc_d  = packed_word;
                    fill_d = last ? 2'd0 : fill_q + 2'd1;
                end
                if (last) begin
                    out_data_d   = packed_word;
                    out_en_d     = 1'b1;
                    out_first_d  = first_pend_q | copy;
                    first_pend_d = 1'b0;
                end
            end else begin
                dcnt_d = dcnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q     <= 1'b0;
            cmode_q      <= 2'd0;
            cdecim_q     <= 4'd0;
            first_pend_q <= 1'b0;
            dcnt_q       <= 4'd0;
            fill_q       <= 2'd0;
            acc_q        <= 16'd0;
            tcnt_q       <= 16'd0;
            out_data_q   <= 16'd0;
            out_en_q     <= 1'b0;
            out_first_q  <= 1'b0;
        end else begin
            enable_q     <= enable_d;
            cmode_q      <= cmode_d;
            cdecim_q     <= cdecim_d;
            first_pend_q <= first_pend_d;
            dcnt_q       <= dcnt_d;
            fill_q       <= fill_d;
            acc_q        <= acc_d;
            tcnt_q       <= tcnt_d;
            out_data_q   <= out_data_d;
            out_en_q     <= out_en_d;
            out_first_q  <= out_first_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_en    = out_en_q;
    assign out_first = out_first_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer: stimulus pushes {cycle, first, data} into a
// queue, a negedge monitor pops and compares on every out_en strobe.
module tb_sample_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ch1_s, ch2_s, ch3_s, ch4_s;
    logic        enable;
    logic [1:0]  mode;
    logic [3:0]  decim;
    logic [15:0] out_data;
    logic        out_en;
    logic        out_first;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [48:0] exp_q[$];
    logic [48:0] mon_e;

    sample_packer dut (
        .clk       (clk),
        .reset     (reset),
        .ch1_s     (ch1_s),
        .ch2_s     (ch2_s),
        .ch3_s     (ch3_s),
        .ch4_s     (ch4_s),
        .enable    (enable),
        .mode      (mode),
        .decim     (decim),
        .out_data  (out_data),
        .out_en    (out_en),
        .out_first (out_first)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock: drive inputs, let the edge capture them, return 1 time unit later
    task automatic step(input logic en, input logic [1:0] m, input logic [3:0] d,
                        input logic [3:0] c1, input logic [3:0] c2,
                        input logic [3:0] c3, input logic [3:0] c4);
        enable = en;
        mode   = m;
        decim  = d;
        ch1_s  = c1;
        ch2_s  = c2;
        ch3_s  = c3;
        ch4_s  = c4;
        @(posedge clk);
        #1;
    endtask

    // word expected to be strobed by the edge just taken
    task automatic expect_word(input logic f, input logic [15:0] w);
        logic [31:0] c;
        c = cyc;
        exp_q.push_back({c, f, w});
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (out_en !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got out_en=%b data 0x%0h at cycle %0d, expected no word",
                         out_en, out_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("word{cycle,first,data}", {15'd0, 32'(cyc), out_first, out_data}, {15'd0, mon_e});
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL timeout: simulation did not complete, %0d words outstanding", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        mode   = 2'd0;
        decim  = 4'd0;
        ch1_s  = 4'd0;
        ch2_s  = 4'd0;
        ch3_s  = 4'd0;
        ch4_s  = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_out_data", 64'(out_data), 64'h0);
        check("reset_out_en", 64'(out_en), 64'h0);
        check("reset_out_first", 64'(out_first), 64'h0);
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0);

        // mode 0 packing: 1..8 -> 0x1234, 0x5678
        step(1, 0, 0, 4'hF, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 0, 4'(i), 0, 0, 0);
            if (i == 4) expect_word(1'b1, 16'h1234);
            if (i == 8) expect_word(1'b0, 16'h5678);
        end
        step(0, 0, 0, 0, 0, 0, 0);

        // partial word dropped, re-enable starts fresh
        step(1, 0, 0, 4'hF, 0, 0, 0);
        step(1, 0, 0, 4'h9, 0, 0, 0);
        step(1, 0, 0, 4'hA, 0, 0, 0);
        step(0, 0, 0, 4'hB, 0, 0, 0);
        step(0, 0, 0, 4'hB, 0, 0, 0);
        step(1, 0, 0, 4'h7, 0, 0, 0);
        step(1, 0, 0, 4'hB, 0, 0, 0);
        step(1, 0, 0, 4'hC, 0, 0, 0);
        step(1, 0, 0, 4'hD, 0, 0, 0);
        step(1, 0, 0, 4'hE, 0, 0, 0);
        expect_word(1'b1, 16'hBCDE);

        // mode 0 -> 2 mid-word: word finishes in mode 0, then mode 2 words
        step(1, 0, 0, 4'h1, 0, 0, 0);
        step(1, 0, 0, 4'h2, 0, 0, 0);
        step(1, 2, 0, 4'h3, 4'h7, 4'h7, 4'h7);
        step(1, 2, 0, 4'h4, 4'h7, 4'h7, 4'h7);
        expect_word(1'b0, 16'h1234);
        step(1, 2, 0, 4'h1, 4'h2, 4'h3, 4'h4);
        expect_word(1'b1, 16'h1234);
        step(1, 2, 0, 4'h5, 4'h6, 4'h7, 4'h8);
        expect_word(1'b0, 16'h5678);
        step(1, 2, 0, 4'h9, 4'hA, 4'hB, 4'hC);
        expect_word(1'b0, 16'h9ABC);
        step(1, 2, 0, 4'hD, 4'hE, 4'hF, 4'h0);
        expect_word(1'b0, 16'hDEF0);
        step(0, 2, 0, 0, 0, 0, 0);

        // mode 1, decim 2: samples taken at steps 1,4,7,...; words every 6 cycles
        step(1, 1, 2, 4'hF, 4'hF, 4'hF, 4'hF);
        for (int i = 1; i <= 18; i++) begin
            if (i % 3 == 1) step(1, 1, 2, 4'hA, 4'hF, 4'h5, 4'hF);
            else            step(1, 1, 2, 4'hF, 4'hF, 4'hF, 4'hF);
            if (i % 6 == 4) expect_word(i == 4, 16'hA5A5);
        end
        step(0, 1, 2, 0, 0, 0, 0);

        // enable dropped on the edge that would complete a word
        step(1, 0, 0, 4'hF, 0, 0, 0);
        step(1, 0, 0, 4'h1, 0, 0, 0);
        step(1, 0, 0, 4'h2, 0, 0, 0);
        step(1, 0, 0, 4'h3, 0, 0, 0);
        step(0, 0, 0, 4'h4, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // test counter through wrap, then restart
        step(1, 3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65538; i++) begin
            step(1, 3, 0, 0, 0, 0, 0);
            expect_word(i == 0, 16'(i));
        end
        step(0, 3, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0);
        expect_word(1'b1, 16'h0000);
        step(0, 3, 0, 0, 0, 0, 0);

        // asynchronous reset while mode 2 is streaming
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 2, 0, 4'h1, 4'h2, 4'h3, 4'h4);
        expect_word(1'b1, 16'h1234);
        step(1, 2, 0, 4'h5, 4'h6, 4'h7, 4'h8);
        expect_word(1'b0, 16'h5678);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_out_en", 64'(out_en), 64'h0);
        check("async_reset_out_data", 64'(out_data), 64'h0);
        check("async_reset_out_first", 64'(out_first), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 2, 0, 4'h1, 4'h2, 4'h3, 4'h4);
            check("held_reset_out_en", 64'(out_en), 64'h0);
        end
        reset = 1'b0;
        step(1, 2, 0, 4'h1, 4'h2, 4'h3, 4'h4);
        step(1, 2, 0, 4'hC, 4'hD, 4'hE, 4'hF);
        expect_word(1'b1, 16'hCDEF);
        step(0, 2, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        check("words_outstanding", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
